// File: rtl/i2s_rx_pkg.sv
// I2S receiver shared types.
// Slot FSM encoding and framing-mode constants.
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam int CNT_W = 6;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for the I2S bus lines.
// Bit 0 carries bclk and gets an extra flop for edge detection.
module i2s_rx_sync #(
  parameter int W      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:1] q,
  output logic         rise,
  output logic         fall
);

  logic [STAGES-1:0][W-1:0] pipe;
  logic                     bclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe   <= '0;
      bclk_d <= 1'b0;
    end else begin
      pipe   <= {pipe[STAGES-2:0], d};
      bclk_d <= pipe[STAGES-1][0];
    end
  end

  assign q    = pipe[STAGES-1][W-1:1];
  assign rise = pipe[STAGES-1][0] & ~bclk_d;
  assign fall = ~pipe[STAGES-1][0] & bclk_d;

endmodule

// File: rtl/i2s_rx_multimode.sv
// I2S / left-justified serial audio receiver on the fabric clock.
// Oversamples bclk, frames slots on WS changes, flags short slots.
module i2s_rx_multimode
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RSTn_i,
  input  logic                  i2s_clk_i,
  input  logic                  i2s_ws_clk_i,
  input  logic                  i2s_din_i,
  input  logic                  I2S_S_EN_i,
  input  logic                  LJ_MODE_i,
  output logic [DATA_WIDTH-1:0] data_left_o,
  output logic [DATA_WIDTH-1:0] data_right_o,
  output logic                  push_left_o,
  output logic                  push_right_o,
  output logic                  frame_err_o,
  output logic                  i2s_dis_o
);

  localparam logic [CNT_W-1:0] DW = CNT_W'(DATA_WIDTH);

  logic [2:1] sync_q;
  logic       rise, fall;
  logic       ws_s, din_s;

  rx_state_t             state_q, state_d;
  logic                  lj_q;
  logic                  ws_prev, ws_ok;
  logic [CNT_W-1:0]      cnt_q, cnt_end;
  logic [DATA_WIDTH-1:0] sh_q, word_shift, word_end;
  logic [TIMEOUT_W-1:0]  to_cnt;

  logic en, flush, sample, boundary, full;
  logic push_l_d, push_r_d, err_d;

  i2s_rx_sync #(
    .W      (3),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (WBs_CLK_i),
    .rst_n (WBs_RSTn_i),
    .d     ({i2s_din_i, i2s_ws_clk_i, i2s_clk_i}),
    .q     (sync_q),
    .rise  (rise),
    .fall  (fall)
  );

  assign ws_s   = sync_q[1];
  assign din_s  = sync_q[2];
  assign en     = I2S_S_EN_i;
  // A timed-out or disabled bus wipes all slot progress.
  assign flush  = !en || to_cnt[TIMEOUT_W-1];
  assign sample = rise && !flush;
  assign boundary = sample && ws_ok && (ws_s != ws_prev);

  always_comb begin
    state_d    = state_q;
    word_shift = {sh_q[DATA_WIDTH-2:0], din_s};
    word_end   = sh_q;
    cnt_end    = cnt_q;
    // In I2S framing the boundary bit still belongs to the old slot.
    if (lj_q == MODE_I2S && cnt_q < DW) begin
      word_end = word_shift;
      cnt_end  = cnt_q + CNT_W'(1);
    end
    full     = cnt_end >= DW;
    push_l_d = boundary && state_q == ST_LEFT && full;
    push_r_d = boundary && state_q == ST_RIGHT && full;
    err_d    = boundary && state_q != ST_IDLE && !full;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (boundary) begin
      state_d = ws_s ? ST_RIGHT : ST_LEFT;
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      lj_q         <= MODE_I2S;
      ws_prev      <= 1'b0;
      ws_ok        <= 1'b0;
      cnt_q        <= '0;
      sh_q         <= '0;
      to_cnt       <= '0;
      data_left_o  <= '0;
      data_right_o <= '0;
      push_left_o  <= 1'b0;
      push_right_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      push_left_o  <= push_l_d;
      push_right_o <= push_r_d;
      frame_err_o  <= err_d;
      if (state_q == ST_IDLE) begin
        lj_q <= LJ_MODE_i;
      end
      if (!en) begin
        data_left_o  <= '0;
        data_right_o <= '0;
      end else begin
        if (push_l_d) data_left_o <= word_end;
        if (push_r_d) data_right_o <= word_end;
      end
      if (flush) begin
        ws_prev <= 1'b0;
        ws_ok   <= 1'b0;
        cnt_q   <= '0;
        sh_q    <= '0;
      end else if (sample) begin
        ws_prev <= ws_s;
        ws_ok   <= 1'b1;
        if (boundary && lj_q == MODE_LJ) begin
          cnt_q <= CNT_W'(1);
          sh_q  <= {{(DATA_WIDTH-1){1'b0}}, din_s};
        end else if (boundary) begin
          cnt_q <= '0;
          sh_q  <= '0;
        end else if (cnt_q < DW) begin
          cnt_q <= cnt_q + CNT_W'(1);
          sh_q  <= word_shift;
        end
      end
      if (!en || rise || fall) begin
        to_cnt <= '0;
      end else if (!(&to_cnt)) begin
        to_cnt <= to_cnt + TIMEOUT_W'(1);
      end
    end
  end

  assign i2s_dis_o = to_cnt[TIMEOUT_W-1];

endmodule

// File: tb/tb_i2s_rx_multimode.sv
// Directed bench for i2s_rx_multimode: I2S 16-bit and LJ 24-bit instances.
// Frame vectors come from a table; timeout, enable and reset are hand sequences.
module tb_i2s_rx_multimode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic bclk_a, ws_a, din_a, en_a;
  logic bclk_b, ws_b, din_b;

  logic [15:0] dl_a, dr_a;
  logic        pl_a, pr_a, err_a, dis_a;
  logic [23:0] dl_b, dr_b;
  logic        pl_b, pr_b, err_b, dis_b;

  i2s_rx_multimode #(.DATA_WIDTH(16)) dut_a (
    .WBs_CLK_i    (clk),
    .WBs_RSTn_i   (rst_n),
    .i2s_clk_i    (bclk_a),
    .i2s_ws_clk_i (ws_a),
    .i2s_din_i    (din_a),
    .I2S_S_EN_i   (en_a),
    .LJ_MODE_i    (1'b0),
    .data_left_o  (dl_a),
    .data_right_o (dr_a),
    .push_left_o  (pl_a),
    .push_right_o (pr_a),
    .frame_err_o  (err_a),
    .i2s_dis_o    (dis_a)
  );

  i2s_rx_multimode #(.DATA_WIDTH(24)) dut_b (
    .WBs_CLK_i    (clk),
    .WBs_RSTn_i   (rst_n),
    .i2s_clk_i    (bclk_b),
    .i2s_ws_clk_i (ws_b),
    .i2s_din_i    (din_b),
    .I2S_S_EN_i   (1'b1),
    .LJ_MODE_i    (1'b1),
    .data_left_o  (dl_b),
    .data_right_o (dr_b),
    .push_left_o  (pl_b),
    .push_right_o (pr_b),
    .frame_err_o  (err_b),
    .i2s_dis_o    (dis_b)
  );

  int total = 0;
  int bad   = 0;

  int npl[2]     = '{0, 0};
  int npr[2]     = '{0, 0};
  int nerr[2]    = '{0, 0};
  int last_ch[2] = '{0, 0};
  int nboth      = 0;

  always @(negedge clk) begin
    if (pl_a) begin npl[0] <= npl[0] + 1; last_ch[0] <= 0; end
    if (pr_a) begin npr[0] <= npr[0] + 1; last_ch[0] <= 1; end
    if (err_a) nerr[0] <= nerr[0] + 1;
    if (pl_b) begin npl[1] <= npl[1] + 1; last_ch[1] <= 0; end
    if (pr_b) begin npr[1] <= npr[1] + 1; last_ch[1] <= 1; end
    if (err_b) nerr[1] <= nerr[1] + 1;
    if ((pl_a && pr_a) || (pl_b && pr_b)) nboth <= nboth + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic q_ws[$];
  logic q_dat[$];

  function automatic void add_slot(input logic ws, input logic [31:0] w,
                                   input int n, input int width);
    for (int i = 0; i < n; i++) begin
      q_ws.push_back(ws);
      q_dat.push_back(i < width ? w[width-1-i] : 1'b0);
    end
  endfunction

  task automatic drive(input int sel, input logic c, input logic w,
                       input logic d);
    if (sel == 0) begin
      bclk_a = c; ws_a = w; din_a = d;
    end else begin
      bclk_b = c; ws_b = w; din_b = d;
    end
  endtask

  task automatic send_bit(input int sel, input logic w, input logic d);
    drive(sel, 1'b0, w, d);
    repeat (4) @(negedge clk);
    drive(sel, 1'b1, w, d);
    repeat (4) @(negedge clk);
  endtask

  // dly=1 produces I2S framing: data lags WS by one bit clock.
  task automatic play(input int sel, input bit dly);
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < q_ws.size(); i++) begin
      send_bit(sel, q_ws[i], dly ? prev : q_dat[i]);
      prev = q_dat[i];
    end
    q_ws.delete();
    q_dat.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dl_a"}, 32'(dl_a), 32'h0);
    chk({nm, "_dr_a"}, 32'(dr_a), 32'h0);
    chk({nm, "_strb_a"}, {28'h0, pl_a, pr_a, err_a, dis_a}, 32'h0);
    chk({nm, "_dl_b"}, 32'(dl_b), 32'h0);
    chk({nm, "_dr_b"}, 32'(dr_b), 32'h0);
    chk({nm, "_strb_b"}, {28'h0, pl_b, pr_b, err_b, dis_b}, 32'h0);
  endtask

  typedef struct {
    int          sel;
    bit          dly;
    int          nl;
    int          nr;
    logic [31:0] wl;
    logic [31:0] wr;
    int          dpl;
    int          dpr;
    int          derr;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;

  vec_t vt[6];
  int   s, w, b_pl, b_pr, b_er;

  initial begin
    vt[0] = '{0, 1'b1, 16, 16, 32'hA5C3, 32'h1234, 1, 1, 0,
              32'hA5C3, 32'h1234};
    vt[1] = '{0, 1'b1, 16, 10, 32'hBEEF, 32'h5555, 1, 0, 1,
              32'hBEEF, 32'h1234};
    vt[2] = '{0, 1'b1, 10, 16, 32'h0F0F, 32'hC001, 0, 1, 1,
              32'hBEEF, 32'hC001};
    vt[3] = '{1, 1'b0, 24, 24, 32'hABCDEF, 32'h135790, 1, 1, 0,
              32'hABCDEF, 32'h135790};
    vt[4] = '{1, 1'b1, 24, 24, 32'hABCDEF, 32'h000000, 1, 1, 0,
              32'h55E6F7, 32'h800000};
    vt[5] = '{1, 1'b0, 32, 32, 32'h123456, 32'hFEDCBA, 1, 1, 0,
              32'h123456, 32'hFEDCBA};

    rst_n = 1'b0;
    en_a  = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1);
    chk_zero("release");

    for (int k = 0; k < 6; k++) begin
      s    = vt[k].sel;
      w    = (s == 1) ? 24 : 16;
      b_pl = npl[s];
      b_pr = npr[s];
      b_er = nerr[s];
      add_slot(1'b1, 32'h0, 4, w);
      add_slot(1'b0, vt[k].wl, vt[k].nl, w);
      add_slot(1'b1, vt[k].wr, vt[k].nr, w);
      add_slot(1'b0, 32'h0, 2, w);
      play(s, vt[k].dly);
      idle(200);
      chk($sformatf("v%0d_push_l", k), 32'(npl[s] - b_pl), 32'(vt[k].dpl));
      chk($sformatf("v%0d_push_r", k), 32'(npr[s] - b_pr), 32'(vt[k].dpr));
      chk($sformatf("v%0d_ferr", k), 32'(nerr[s] - b_er), 32'(vt[k].derr));
      chk($sformatf("v%0d_left", k), s ? 32'(dl_b) : 32'(dl_a), vt[k].el);
      chk($sformatf("v%0d_right", k), s ? 32'(dr_b) : 32'(dr_a), vt[k].er);
      if (vt[k].dpl > 0 && vt[k].dpr > 0)
        chk($sformatf("v%0d_order", k), 32'(last_ch[s]), 32'd1);
    end

    // bclk stops, then restarts into a partial slot
    add_slot(1'b0, 32'h0, 1, 16);
    play(0, 1'b1);
    idle(100);
    chk("dis_early", 32'(dis_a), 32'h0);
    idle(50);
    chk("dis_set", 32'(dis_a), 32'h1);
    b_pl = npl[0];
    b_pr = npr[0];
    b_er = nerr[0];
    add_slot(1'b0, 32'h0, 1, 16);
    play(0, 1'b1);
    chk("dis_clear", 32'(dis_a), 32'h0);
    add_slot(1'b0, 32'hFFFF, 4, 16);
    add_slot(1'b1, 32'hFFFF, 3, 16);
    play(0, 1'b1);
    chk("partial_push", 32'(npl[0] - b_pl + npr[0] - b_pr), 32'h0);
    chk("partial_err", 32'(nerr[0] - b_er), 32'h0);
    idle(200);

    // enable falls mid-slot
    b_pl = npl[0];
    b_pr = npr[0];
    b_er = nerr[0];
    add_slot(1'b1, 32'h0, 4, 16);
    add_slot(1'b0, 32'hFFFF, 8, 16);
    play(0, 1'b1);
    en_a = 1'b0;
    idle(4);
    chk("en_off_left", 32'(dl_a), 32'h0);
    chk("en_off_right", 32'(dr_a), 32'h0);
    chk("en_off_dis", 32'(dis_a), 32'h0);
    en_a = 1'b1;
    add_slot(1'b0, 32'hFFFF, 8, 16);
    add_slot(1'b1, 32'h4321, 16, 16);
    add_slot(1'b0, 32'h0, 2, 16);
    play(0, 1'b1);
    idle(200);
    chk("en_push_l", 32'(npl[0] - b_pl), 32'h0);
    chk("en_push_r", 32'(npr[0] - b_pr), 32'h1);
    chk("en_ferr", 32'(nerr[0] - b_er), 32'h0);
    chk("en_right", 32'(dr_a), 32'h4321);

    // asynchronous reset in the middle of a frame
    add_slot(1'b1, 32'h0, 4, 16);
    add_slot(1'b0, 32'h1111, 16, 16);
    add_slot(1'b1, 32'h2222, 16, 16);
    add_slot(1'b0, 32'h0, 6, 16);
    play(0, 1'b1);
    chk("pre_rst_left", 32'(dl_a), 32'h1111);
    chk("pre_rst_right", 32'(dr_a), 32'h2222);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk_zero("post_rst");

    chk("no_dual_push", 32'(nboth), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
